// File: rtl/rob_pkg.sv
// Shared ROB constants, entry type encodings and the operand lookup result type.
package rob_pkg;

    localparam int unsigned ROB_SIZE_WIDTH = 3;
    localparam int unsigned REG_NUM_WIDTH  = 5;
    localparam int unsigned ROB_SIZE       = 1 << ROB_SIZE_WIDTH;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } lookup_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue that allocates in issue order, captures CDB results and
// retires one entry per cycle in program order, flushing the pipeline on a branch mispredict.
module rob
    import rob_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      dec_valid,
    input  logic [1:0]                dec_type,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic                      dec_pred_taken,
    input  logic [31:0]               dec_alt_pc,
    output logic                      full_out,
    output logic [ROB_SIZE_WIDTH-1:0] tail_out,
    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic                      cdb_taken,
    input  logic [ROB_SIZE_WIDTH-1:0] qj_tag,
    input  logic [ROB_SIZE_WIDTH-1:0] qk_tag,
    output logic                      qj_ready,
    output logic                      qk_ready,
    output logic [31:0]               qj_value,
    output logic [31:0]               qk_value,
    output logic                      rf_valid,
    output logic [REG_NUM_WIDTH-1:0]  rf_rd,
    output logic [31:0]               rf_value,
    output logic [ROB_SIZE_WIDTH-1:0] rf_dependency,
    output logic                      lsb_commit_valid,
    output logic [ROB_SIZE_WIDTH-1:0] lsb_commit_tag,
    output logic                      flush_out,
    output logic [31:0]               flush_pc_out
);

    logic [ROB_SIZE_WIDTH-1:0] head_q, tail_q;
    logic [ROB_SIZE_WIDTH:0]   count_q;
    logic [ROB_SIZE-1:0]       ready_q, taken_q, pred_q;
    rob_type_e                 type_q   [ROB_SIZE];
    logic [REG_NUM_WIDTH-1:0]  rd_q     [ROB_SIZE];
    logic [31:0]               value_q  [ROB_SIZE];
    logic [31:0]               alt_pc_q [ROB_SIZE];

    logic                      alloc, wb, commit, mispredict;
    logic [ROB_SIZE_WIDTH-1:0] wb_offset;
    lookup_t                   qj, qk;

    // A CDB hit on an in-flight tag forwards the bus value ahead of the entry write.
    function automatic lookup_t lookup(input logic [ROB_SIZE_WIDTH-1:0] tag,
                                       input logic entry_ready,
                                       input logic [31:0] entry_value,
                                       input logic bus_valid,
                                       input logic [ROB_SIZE_WIDTH-1:0] bus_tag,
                                       input logic [31:0] bus_value);
        lookup_t res;
        if (bus_valid && bus_tag == tag) begin
            res.ready = 1'b1;
            res.value = bus_value;
        end else begin
            res.ready = entry_ready;
            res.value = entry_value;
        end
        return res;
    endfunction

    always_comb begin
        full_out   = (count_q == (ROB_SIZE_WIDTH + 1)'(ROB_SIZE));
        tail_out   = tail_q;
        alloc      = dec_valid && !full_out && !flush_out;
        // Tag is allocated iff its distance from head is below the occupancy.
        wb_offset  = cdb_tag - head_q;
        wb         = cdb_valid && !flush_out && ({1'b0, wb_offset} < count_q);
        commit     = (count_q != '0) && ready_q[head_q];
        mispredict = commit && (type_q[head_q] == ROB_TYPE_BRANCH) &&
                     (taken_q[head_q] != pred_q[head_q]);
        qj = lookup(qj_tag, ready_q[qj_tag], value_q[qj_tag], cdb_valid, cdb_tag, cdb_value);
        qk = lookup(qk_tag, ready_q[qk_tag], value_q[qk_tag], cdb_valid, cdb_tag, cdb_value);
        qj_ready = qj.ready;
        qj_value = qj.value;
        qk_ready = qk.ready;
        qk_value = qk.value;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            ready_q          <= '0;
            rf_valid         <= 1'b0;
            rf_rd            <= '0;
            rf_value         <= '0;
            rf_dependency    <= '0;
            lsb_commit_valid <= 1'b0;
            lsb_commit_tag   <= '0;
            flush_out        <= 1'b0;
            flush_pc_out     <= '0;
        end else if (rdy_in) begin
            rf_valid         <= 1'b0;
            lsb_commit_valid <= 1'b0;
            flush_out        <= 1'b0;
            if (mispredict) begin
                flush_out    <= 1'b1;
                flush_pc_out <= alt_pc_q[head_q];
                head_q       <= '0;
                tail_q       <= '0;
                count_q      <= '0;
                ready_q      <= '0;
            end else begin
                if (alloc) begin
                    type_q[tail_q]   <= rob_type_e'(dec_type);
                    rd_q[tail_q]     <= dec_rd;
                    pred_q[tail_q]   <= dec_pred_taken;
                    alt_pc_q[tail_q] <= dec_alt_pc;
                    ready_q[tail_q]  <= 1'b0;
                    tail_q           <= tail_q + ROB_SIZE_WIDTH'(1);
                end
                if (wb) begin
                    value_q[cdb_tag] <= cdb_value;
                    taken_q[cdb_tag] <= cdb_taken;
                    ready_q[cdb_tag] <= 1'b1;
                end
                if (commit) begin
                    head_q <= head_q + ROB_SIZE_WIDTH'(1);
                    unique case (type_q[head_q])
                        ROB_TYPE_REG: begin
                            rf_valid      <= 1'b1;
                            rf_rd         <= rd_q[head_q];
                            rf_value      <= value_q[head_q];
                            rf_dependency <= head_q;
                        end
                        ROB_TYPE_STORE: begin
                            lsb_commit_valid <= 1'b1;
                            lsb_commit_tag   <= head_q;
                        end
                        default: ;
                    endcase
                end
                if (alloc && !commit) begin
                    count_q <= count_q + (ROB_SIZE_WIDTH + 1)'(1);
                end else if (commit && !alloc) begin
                    count_q <= count_q - (ROB_SIZE_WIDTH + 1)'(1);
                end
            end
        end
    end

endmodule
